// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, command bytes and
// the receive-side key codes used by the direction decoder.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SEND,
        WAIT_ACK,
        DONE,
        ERROR
    } tx_state_t;

    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_ACK         = 8'hFA;

    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_RIGHT = 8'h74;

    // Bits still to shift after the start bit: data LSB first, odd parity, stop.
    function automatic logic [9:0] ps2_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one raw PS/2 line, plus a falling-edge detector
// on the synchronized value.
module ps2_sync_edge (
    input  logic VGA_clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic fall
);

    // [0] first sync flop, [1] synced current value, [2] synced previous value
    logic [2:0] sync_q;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge value of its neighbour and the chain
    // really is three stages deep.
    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            // Idle lines are pulled high; resetting to 1 avoids a phantom edge.
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], din};
        end
    end

    assign level = sync_q[1];
    assign fall  = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, clocked-out frame driven
// by the device clock, ACK check and watchdog on the open-drain lines.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ       = 25000000,
    parameter int INHIBIT_CYCLES    = 3000,
    parameter int START_HOLD_CYCLES = 50,
    parameter int TIMEOUT_CYCLES    = 375000
) (
    input  logic       VGA_clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    // The device needs at least 100 us of inhibit; never go below that floor.
    localparam int MIN_INHIBIT = CLK_FREQ_HZ / 10000;
    localparam int INHIBIT_EFF = (INHIBIT_CYCLES > MIN_INHIBIT) ? INHIBIT_CYCLES : MIN_INHIBIT;
    localparam int CNT_MAX_A   = (INHIBIT_EFF > START_HOLD_CYCLES) ? INHIBIT_EFF : START_HOLD_CYCLES;
    localparam int CNT_MAX     = (TIMEOUT_CYCLES > CNT_MAX_A) ? TIMEOUT_CYCLES : CNT_MAX_A;
    localparam int CNT_W       = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_EFF - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(START_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    tx_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       bit_cnt, bit_cnt_n;
    logic [9:0]       shreg, shreg_n;
    logic             data_oe_q, data_oe_n;

    logic clk_fall;
    logic clk_level_unused;
    logic data_level;
    logic data_fall_unused;

    ps2_sync_edge u_clk_sync (
        .VGA_clk (VGA_clk),
        .reset   (reset),
        .din     (ps2_clk_in),
        .level   (clk_level_unused),
        .fall    (clk_fall)
    );

    ps2_sync_edge u_data_sync (
        .VGA_clk (VGA_clk),
        .reset   (reset),
        .din     (ps2_data_in),
        .level   (data_level),
        .fall    (data_fall_unused)
    );

    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            data_oe_q <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            data_oe_q <= data_oe_n;
        end
    end

    // NOTE: every variable gets its hold value first, so no branch below can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        data_oe_n = data_oe_q;

        case (state)
            IDLE: begin
                cnt_n     = '0;
                bit_cnt_n = '0;
                data_oe_n = 1'b0;
                if (tx_valid) begin
                    shreg_n = ps2_frame(tx_data);
                    state_n = INHIBIT;
                end
            end

            INHIBIT: begin
                if (cnt == INHIBIT_LAST) begin
                    cnt_n   = '0;
                    state_n = START;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            START: begin
                if (cnt == HOLD_LAST) begin
                    cnt_n     = '0;
                    bit_cnt_n = '0;
                    data_oe_n = 1'b1;   // keep the start bit on the line
                    state_n   = SEND;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            SEND: begin
                if (clk_fall) begin
                    cnt_n     = '0;
                    data_oe_n = ~shreg[0];
                    shreg_n   = {1'b0, shreg[9:1]};
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == 4'd9) begin
                        state_n = WAIT_ACK;
                    end
                end else if (cnt == TIMEOUT_LAST) begin
                    state_n = ERROR;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            WAIT_ACK: begin
                data_oe_n = 1'b0;
                if (clk_fall) begin
                    cnt_n   = '0;
                    state_n = data_level ? ERROR : DONE;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_n = ERROR;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            DONE, ERROR: begin
                cnt_n     = '0;
                data_oe_n = 1'b0;
                state_n   = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign tx_ready    = (state == IDLE);
    assign busy        = (state != IDLE);
    assign tx_done     = (state == DONE);
    assign tx_error    = (state == ERROR);
    assign ps2_clk_oe  = (state == INHIBIT) || (state == START);
    assign ps2_data_oe = (state == START) || ((state == SEND) && data_oe_q);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a behavioural PS/2 device clocks the
// frame out, and every observed field is checked against the byte sent.
module tb_ps2_host_tx;

    localparam int INH  = 3000;
    localparam int HOLD = 50;
    localparam int TMO  = 2000;
    localparam int HALF = 40;

    logic       VGA_clk  = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_error, busy;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       ps2_clk_in, ps2_data_in;
    logic       dev_clk  = 1'b1;
    logic       dev_data = 1'b1;

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    // Open-drain bus: the line is low if either side pulls it low.
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .CLK_FREQ_HZ       (25000000),
        .INHIBIT_CYCLES    (INH),
        .START_HOLD_CYCLES (HOLD),
        .TIMEOUT_CYCLES    (TMO)
    ) dut (
        .VGA_clk     (VGA_clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .tx_error    (tx_error),
        .busy        (busy),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 VGA_clk = ~VGA_clk;

    always @(negedge VGA_clk) begin
        if (tx_done)              done_cnt++;
        if (tx_error)             err_cnt++;
        if (tx_done && tx_error)  both_cnt++;
    end

    // Line levels a device should see: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] expected_frame(input logic [7:0] b);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        f[9]  = ($countones(b) % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic start_tx(input logic [7:0] b);
        int n = 0;
        while (!tx_ready && n < 20000) begin
            n++;
            @(negedge VGA_clk);
        end
        checks++;
        if (!tx_ready) begin
            errors++;
            $display("FAIL start_tx_ready: tx_ready=%b after %0d cycles, required 1", tx_ready, n);
        end
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge VGA_clk);
        tx_valid = 1'b0;
    endtask

    // Counts inhibit and start-hold cycles; returns on the first released-clock cycle.
    task automatic measure_phases(output int inh, output int hold);
        inh  = 0;
        hold = 0;
        while (ps2_clk_oe && !ps2_data_oe && inh < 20000) begin
            inh++;
            @(negedge VGA_clk);
        end
        while (ps2_clk_oe && ps2_data_oe && hold < 20000) begin
            hold++;
            @(negedge VGA_clk);
        end
    endtask

    task automatic wait_release();
        int n = 0;
        while (!(busy && !ps2_clk_oe) && n < 20000) begin
            n++;
            @(negedge VGA_clk);
        end
        checks++;
        if (!(busy && !ps2_clk_oe)) begin
            errors++;
            $display("FAIL wait_release: busy=%b clk_oe=%b after %0d cycles, required busy=1 clk_oe=0",
                     busy, ps2_clk_oe, n);
        end
    endtask

    // Device model: n falling edges, data sampled just before each rising edge.
    task automatic device_clock(input int n, input logic ack, output logic [10:0] s);
        s = '1;
        for (int k = 0; k < n; k++) begin
            repeat (HALF) @(negedge VGA_clk);
            if (k == 0) s[0] = ps2_data_in;
            if (k == 10) begin
                dev_data = ~ack;
                repeat (5) @(negedge VGA_clk);
            end
            dev_clk = 1'b0;
            repeat (HALF) @(negedge VGA_clk);
            if (k < 10) s[k+1] = ps2_data_in;
            dev_clk = 1'b1;
        end
        dev_data = 1'b1;
    endtask

    task automatic check_frame(input string name, input logic [10:0] s, input logic [7:0] b);
        logic [10:0] e;
        e = expected_frame(b);
        checks++;
        if (s[8:1] !== b) begin
            errors++;
            $display("FAIL %s_data: observed %h, required %h", name, s[8:1], b);
        end
        checks++;
        if (s[9] !== e[9]) begin
            errors++;
            $display("FAIL %s_parity: observed %b, required %b", name, s[9], e[9]);
        end
        checks++;
        if (s[0] !== 1'b0 || s[10] !== 1'b1) begin
            errors++;
            $display("FAIL %s_start_stop: observed start=%b stop=%b, required 0/1", name, s[0], s[10]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge VGA_clk);
        reset = 1'b0;
        @(negedge VGA_clk);
        checks++;
        if ({tx_ready, busy, tx_done, tx_error} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_status: ready/busy/done/error=%b, required 1000",
                     {tx_ready, busy, tx_done, tx_error});
        end
        checks++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
            errors++;
            $display("FAIL reset_lines: clk_oe/data_oe=%b, required 00", {ps2_clk_oe, ps2_data_oe});
        end
    endtask

    task automatic test_send(input string name, input logic [7:0] b);
        int d0 = done_cnt;
        int e0 = err_cnt;
        int inh, hold;
        logic [10:0] s;
        start_tx(b);
        measure_phases(inh, hold);
        checks++;
        if (inh != INH) begin
            errors++;
            $display("FAIL %s_inhibit: clock held low alone %0d cycles, required %0d", name, inh, INH);
        end
        checks++;
        if (hold != HOLD) begin
            errors++;
            $display("FAIL %s_start_hold: both lines low %0d cycles, required %0d", name, hold, HOLD);
        end
        device_clock(11, 1'b1, s);
        repeat (5) @(negedge VGA_clk);
        check_frame(name, s, b);
        checks++;
        if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
            errors++;
            $display("FAIL %s_pulses: done=%0d error=%0d, required 1/0", name, done_cnt - d0, err_cnt - e0);
        end
        checks++;
        if (tx_ready !== 1'b1 || ps2_data_oe !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: tx_ready=%b data_oe=%b, required 1/0", name, tx_ready, ps2_data_oe);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3; i++) begin
            test_send("random", 8'($urandom));
        end
    endtask

    task automatic test_timeout();
        int d0 = done_cnt;
        int e0 = err_cnt;
        int inh, hold;
        int n = 0;
        start_tx(8'($urandom));
        measure_phases(inh, hold);
        while (!tx_error && n < TMO + 100) begin
            n++;
            @(negedge VGA_clk);
        end
        checks++;
        if (n != TMO) begin
            errors++;
            $display("FAIL timeout_latency: error after %0d cycles, required %0d", n, TMO);
        end
        checks++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_lines: clk_oe/data_oe=%b, required 00", {ps2_clk_oe, ps2_data_oe});
        end
        repeat (3) @(negedge VGA_clk);
        checks++;
        if (done_cnt - d0 != 0 || err_cnt - e0 != 1 || tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_pulses: done=%0d error=%0d ready=%b, required 0/1/1",
                     done_cnt - d0, err_cnt - e0, tx_ready);
        end
    endtask

    task automatic test_no_ack();
        int d0 = done_cnt;
        int e0 = err_cnt;
        logic [7:0] b = 8'($urandom);
        logic [10:0] s;
        start_tx(b);
        wait_release();
        device_clock(11, 1'b0, s);
        repeat (5) @(negedge VGA_clk);
        check_frame("no_ack", s, b);
        checks++;
        if (done_cnt - d0 != 0 || err_cnt - e0 != 1) begin
            errors++;
            $display("FAIL no_ack_pulses: done=%0d error=%0d, required 0/1", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int d0 = done_cnt;
        int e0 = err_cnt;
        logic [10:0] s;
        start_tx(8'($urandom));
        wait_release();
        device_clock(4, 1'b1, s);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_busy: busy=%b after 4 edges, required 1", busy);
        end
        reset = 1'b1;
        @(negedge VGA_clk);
        checks++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
            errors++;
            $display("FAIL midreset_release: clk_oe/data_oe=%b, required 00", {ps2_clk_oe, ps2_data_oe});
        end
        @(negedge VGA_clk);
        reset = 1'b0;
        @(negedge VGA_clk);
        checks++;
        if ({tx_ready, ps2_clk_oe, ps2_data_oe} !== 3'b100) begin
            errors++;
            $display("FAIL midreset_after: ready/clk_oe/data_oe=%b, required 100",
                     {tx_ready, ps2_clk_oe, ps2_data_oe});
        end
        repeat (200) @(negedge VGA_clk);
        checks++;
        if (done_cnt - d0 != 0 || err_cnt - e0 != 0) begin
            errors++;
            $display("FAIL midreset_pulses: done=%0d error=%0d, required 0/0", done_cnt - d0, err_cnt - e0);
        end
        test_send("after_reset", 8'hF4);
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt;
        int e0 = err_cnt;
        logic [10:0] s1, s2;
        logic ready_seen = 1'b0;
        start_tx(8'hFF);
        repeat (100) @(negedge VGA_clk);
        checks++;
        if (tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_ready: tx_ready=%b during transfer, required 0", tx_ready);
        end
        tx_data  = 8'h12;
        tx_valid = 1'b1;
        @(negedge VGA_clk);
        tx_valid = 1'b0;
        wait_release();
        fork
            device_clock(11, 1'b1, s1);
            begin
                for (int n = 0; n < 20000 && !tx_ready; n++) @(negedge VGA_clk);
                ready_seen = tx_ready;
                tx_data    = 8'hF4;
                tx_valid   = 1'b1;
                @(negedge VGA_clk);
                tx_valid   = 1'b0;
            end
        join
        checks++;
        if (ready_seen !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: tx_ready after first frame=%b, required 1", ready_seen);
        end
        wait_release();
        device_clock(11, 1'b1, s2);
        repeat (5) @(negedge VGA_clk);
        check_frame("b2b_first", s1, 8'hFF);
        check_frame("b2b_second", s2, 8'hF4);
        checks++;
        if (done_cnt - d0 != 2 || err_cnt - e0 != 0) begin
            errors++;
            $display("FAIL b2b_pulses: done=%0d error=%0d, required 2/0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    initial begin
        test_reset();
        test_send("set_led", 8'hED);
        test_send("zero", 8'h00);
        test_send("all_ones", 8'hFF);
        test_random();
        test_timeout();
        test_no_ack();
        test_reset_mid_frame();
        test_back_to_back();
        checks++;
        if (both_cnt != 0) begin
            errors++;
            $display("FAIL done_error_overlap: %0d cycles with both pulses, required 0", both_cnt);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
